// File: rtl/div_pkg.sv
// Shared types and constants for the 8-bit restoring divider.
package div_pkg;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned ITERATIONS = 8;
    localparam int unsigned CNT_W      = $clog2(ITERATIONS);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StShift,
        StTrial,
        StHold
    } state_e;

endpackage

// File: rtl/div_datapath.sv
// Divisor, quotient and partial-remainder registers with the trial subtractor.
// Driven by one-hot strobes from the control FSM; holds state when no strobe is set.
module div_datapath
    import div_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ld_d,
    input  logic             init,
    input  logic             init_dbz,
    input  logic             shift,
    input  logic             trial,
    input  logic [WIDTH-1:0] din,
    output logic             d_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH+1:0] sub;
    logic [WIDTH:0]   diff;
    logic             fits;

    // Extra top bit acts as the borrow: clear means R >= D.
    assign sub  = {1'b0, rem_q} - {2'b00, divisor_q};
    assign diff = sub[WIDTH:0];
    assign fits = ~sub[WIDTH+1];

    assign d_zero    = (divisor_q == '0);
    assign quotient  = quot_q;
    assign remainder = rem_q[WIDTH-1:0];

    always_comb begin
        divisor_d = divisor_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        unique case (1'b1)
            ld_d: begin
                divisor_d = din;
            end
            init: begin
                quot_d = din;
                rem_d  = '0;
            end
            init_dbz: begin
                quot_d = '1;
                rem_d  = {1'b0, din};
            end
            shift: begin
                // {R,Q} shifted as one value; R[8] is always 0 here so nothing is lost.
                rem_d  = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
            trial: begin
                if (fits) begin
                    rem_d     = diff;
                    quot_d[0] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            divisor_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
        end else begin
            divisor_q <= divisor_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
        end
    end

endmodule

// File: rtl/restoring_divider.sv
// Unsigned 8-bit restoring divider: control FSM plus iteration count and
// divide-by-zero flag; arithmetic lives in div_datapath.
module restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Execute,
    input  logic             Load_D,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Executing,
    output logic             Done,
    output logic             Div_By_Zero
);

    import div_pkg::*;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic ld_d, init, init_dbz, shift, trial;
    logic d_zero;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dbz_d    = dbz_q;
        ld_d     = 1'b0;
        init     = 1'b0;
        init_dbz = 1'b0;
        shift    = 1'b0;
        trial    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A start request takes priority over a divisor load.
                if (Execute) begin
                    state_d = StInit;
                end else if (Load_D) begin
                    ld_d = 1'b1;
                end
            end
            StInit: begin
                cnt_d = '0;
                dbz_d = d_zero;
                if (d_zero) begin
                    init_dbz = 1'b1;
                    state_d  = StHold;
                end else begin
                    init    = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                shift   = 1'b1;
                state_d = StTrial;
            end
            StTrial: begin
                trial = 1'b1;
                if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
                    state_d = StHold;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = StShift;
                end
            end
            StHold: begin
                if (!Execute) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        Executing   = (state_q == StInit) || (state_q == StShift) || (state_q == StTrial);
        Done        = (state_q == StHold);
        Div_By_Zero = (state_q == StHold) && dbz_q;
    end

    div_datapath u_datapath (
        .Clk       (Clk),
        .Reset     (Reset),
        .ld_d      (ld_d),
        .init      (init),
        .init_dbz  (init_dbz),
        .shift     (shift),
        .trial     (trial),
        .din       (Din),
        .d_zero    (d_zero),
        .quotient  (Quotient),
        .remainder (Remainder)
    );

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider with hand-computed quotients and latencies.
module tb_restoring_divider;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Execute;
    logic       Load_D;
    logic [7:0] Din;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Executing;
    logic       Done;
    logic       Div_By_Zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    restoring_divider #(.WIDTH(8)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Execute     (Execute),
        .Load_D      (Load_D),
        .Din         (Din),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Executing   (Executing),
        .Done        (Done),
        .Div_By_Zero (Div_By_Zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_divisor(input logic [7:0] d);
        Din    = d;
        Load_D = 1'b1;
        tick();
        Load_D = 1'b0;
    endtask

    // Raise Execute and count edges until Done; lat stays -1 if the bound expires.
    task automatic start_run(input logic [7:0] dividend, output int lat, output int exec_bad);
        Din      = dividend;
        Execute  = 1'b1;
        lat      = -1;
        exec_bad = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (Done) begin
                lat = n;
                break;
            end
            if (!Executing) exec_bad++;
        end
    endtask

    task automatic end_run(input string tag);
        Execute = 1'b0;
        tick();
        check({tag, " done_after_release"}, 32'(Done), 32'd0);
    endtask

    int lat, exec_bad, unstable;

    initial begin
        Reset   = 1'b1;
        Execute = 1'b0;
        Load_D  = 1'b0;
        Din     = 8'd0;
        tick();
        tick();
        check("reset quotient", 32'(Quotient), 32'd0);
        check("reset remainder", 32'(Remainder), 32'd0);
        check("reset executing", 32'(Executing), 32'd0);
        check("reset done", 32'(Done), 32'd0);
        check("reset dbz", 32'(Div_By_Zero), 32'd0);
        Reset = 1'b0;
        tick();

        // 100 / 7 = 14 r 2
        load_divisor(8'd7);
        start_run(8'd100, lat, exec_bad);
        check("100/7 latency", 32'(lat), 32'd18);
        check("100/7 executing", 32'(exec_bad), 32'd0);
        check("100/7 quotient", 32'(Quotient), 32'd14);
        check("100/7 remainder", 32'(Remainder), 32'd2);
        check("100/7 dbz", 32'(Div_By_Zero), 32'd0);
        check("100/7 executing in hold", 32'(Executing), 32'd0);

        // Hold with Execute high for 30 cycles; Load_D here must be ignored.
        unstable = 0;
        Din    = 8'd50;
        Load_D = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!Done || Quotient !== 8'd14 || Remainder !== 8'd2) unstable++;
        end
        Load_D = 1'b0;
        check("hold stable", 32'(unstable), 32'd0);
        end_run("100/7");

        // Rerun with Load_D high throughout: D must remain 7.
        Load_D = 1'b1;
        start_run(8'd100, lat, exec_bad);
        Load_D = 1'b0;
        check("load during run quotient", 32'(Quotient), 32'd14);
        check("load during run remainder", 32'(Remainder), 32'd2);
        end_run("rerun");

        // Execute and Load_D together: old divisor 9 is used, 5 / 9 = 0 r 5.
        load_divisor(8'd9);
        Load_D = 1'b1;
        start_run(8'd5, lat, exec_bad);
        Load_D = 1'b0;
        check("5/9 latency", 32'(lat), 32'd18);
        check("5/9 quotient", 32'(Quotient), 32'd0);
        check("5/9 remainder", 32'(Remainder), 32'd5);
        end_run("5/9");

        // 255 / 1 = 255 r 0
        load_divisor(8'd1);
        start_run(8'd255, lat, exec_bad);
        check("255/1 quotient", 32'(Quotient), 32'd255);
        check("255/1 remainder", 32'(Remainder), 32'd0);
        end_run("255/1");

        // Divide by zero: 200 / 0
        load_divisor(8'd0);
        start_run(8'd200, lat, exec_bad);
        check("dbz latency", 32'(lat), 32'd2);
        check("dbz executing", 32'(exec_bad), 32'd0);
        check("dbz quotient", 32'(Quotient), 32'd255);
        check("dbz remainder", 32'(Remainder), 32'd200);
        check("dbz flag", 32'(Div_By_Zero), 32'd1);
        end_run("dbz");
        check("dbz flag after release", 32'(Div_By_Zero), 32'd0);

        // Reset at cycle 8 of a 200 / 13 run.
        load_divisor(8'd13);
        Din     = 8'd200;
        Execute = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("mid-run executing", 32'(Executing), 32'd1);
        Reset   = 1'b1;
        Execute = 1'b0;
        tick();
        Reset = 1'b0;
        check("mid-run reset quotient", 32'(Quotient), 32'd0);
        check("mid-run reset remainder", 32'(Remainder), 32'd0);
        check("mid-run reset executing", 32'(Executing), 32'd0);
        check("mid-run reset done", 32'(Done), 32'd0);
        check("mid-run reset dbz", 32'(Div_By_Zero), 32'd0);
        tick();
        check("idle after reset", 32'(Executing), 32'd0);

        // Divisor was cleared by reset, so reload before the follow-up run: 200 / 13 = 15 r 5.
        load_divisor(8'd13);
        start_run(8'd200, lat, exec_bad);
        check("200/13 latency", 32'(lat), 32'd18);
        check("200/13 quotient", 32'(Quotient), 32'd15);
        check("200/13 remainder", 32'(Remainder), 32'd5);
        check("200/13 dbz", 32'(Div_By_Zero), 32'd0);
        end_run("200/13");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
